// File: rtl/hex_display_mux_if.sv
// Host-side bundle for hex_display_mux: capture handshake, display controls
// and the multiplexed segment/digit drive.
interface hex_display_mux_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic                    blank_lz;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   dig_en;
    logic                    ready;
    logic                    frame;

    modport master (
        output load, value, blank_lz, blink_mask,
        input  seg, dig_en, ready, frame
    );

    modport slave (
        input  load, value, blank_lz, blink_mask,
        output seg, dig_en, ready, frame
    );
endinterface

// File: rtl/hex_display_mux.sv
// Time-multiplexed hex display driver with frame-synchronous shadow loading.
// Optional blinking is built only when HEX_DISPLAY_MUX_BLINK_EN is defined.
module hex_display_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic               clk,
    input  logic               reset,
    hex_display_mux_if.slave   bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0]        scan_cnt;
    logic [IDX_W-1:0]        index;
    logic [4*NUM_DIGITS-1:0] display;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic                    pending;
    logic                    frame_q;
    logic [6:0]              seg_q;
    logic [NUM_DIGITS-1:0]   dig_en_q;
    logic                    tick;
    logic                    boundary;
    logic [3:0]              cur_nibble;
    logic                    cur_lz;
    logic [NUM_DIGITS-1:0]   dig_next;
    logic                    lz_above;
    logic                    blink_hit;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h18;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    assign tick     = (scan_cnt == LAST_CNT);
    assign boundary = tick && (index == LAST_IDX);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt <= '0;
            index    <= '0;
        end else begin
            scan_cnt <= tick ? '0 : scan_cnt + CNT_W'(1);
            if (tick) index <= (index == LAST_IDX) ? '0 : index + IDX_W'(1);
        end
    end

    // Shadow can only be refilled once the previous value reached the display.
    always_ff @(posedge clk) begin
        if (reset) begin
            display <= '0;
            shadow  <= '0;
            pending <= 1'b0;
        end else if (boundary && pending) begin
            display <= shadow;
            pending <= 1'b0;
        end else if (bus.load && !pending) begin
            shadow  <= bus.value;
            pending <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) frame_q <= 1'b0;
        else       frame_q <= boundary;
    end

`ifdef HEX_DISPLAY_MUX_BLINK_EN
    localparam int BL_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BL_W-1:0] LAST_BL = BL_W'(BLINK_FRAMES - 1);

    logic [BL_W-1:0] blink_cnt;
    logic            blink_off;
    logic            cur_mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (boundary) begin
            if (blink_cnt == LAST_BL) begin
                blink_cnt <= '0;
                blink_off <= ~blink_off;
            end else begin
                blink_cnt <= blink_cnt + BL_W'(1);
            end
        end
    end

    always_comb begin
        cur_mask = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (index == IDX_W'(k)) cur_mask = bus.blink_mask[k];
        end
    end

    assign blink_hit = blink_off && cur_mask;
`else
    logic unused_blink_mask;
    assign unused_blink_mask = ^bus.blink_mask;
    assign blink_hit         = 1'b0;
`endif

    // Walk from the top digit down so lz_above means "this and all higher digits are zero".
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cur_nibble = '0;
        cur_lz     = 1'b0;
        dig_next   = '1;
        lz_above   = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            lz_above = lz_above && (display[4*k +: 4] == 4'h0);
            if (index == IDX_W'(k)) begin
                cur_nibble  = display[4*k +: 4];
                cur_lz      = lz_above && (k != 0);
                dig_next[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q    <= 7'h7F;
            dig_en_q <= '1;
        end else begin
            seg_q    <= ((bus.blank_lz && cur_lz) || blink_hit) ? 7'h7F : hex_to_seg(cur_nibble);
            dig_en_q <= dig_next;
        end
    end

    assign bus.seg    = seg_q;
    assign bus.dig_en = dig_en_q;
    assign bus.ready  = ~pending;
    assign bus.frame  = frame_q;
endmodule

// File: tb/tb_hex_display_mux.sv
// Self-checking bench for hex_display_mux (4 digits, SCAN_DIV=4, BLINK_FRAMES=2):
// vector table, hand sequences for handshake/reset corners, and a random run against a model.
module tb_hex_display_mux;
    localparam int ND        = 4;
    localparam int SD        = 4;
    localparam int BF        = 2;
    localparam int FRAME_LEN = ND * SD;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hex_display_mux_if #(.NUM_DIGITS(ND)) bus ();

    hex_display_mux #(
        .NUM_DIGITS  (ND),
        .SCAN_DIV    (SD),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int          m_cyc    = 0;
    logic [15:0] m_disp   = '0;
    logic [15:0] m_shadow = '0;
    bit          m_pend   = 1'b0;
    logic [6:0]  e_seg;
    logic [3:0]  e_dig;
    logic        e_ready;
    logic        e_frame;
    bit          chk_en   = 1'b0;

    function automatic logic [6:0] model_seg(input logic [15:0] disp, input int idx,
                                             input bit lz, input bit blink_blank);
        int upper;
        upper = int'(disp >> (4 * idx));
        if (blink_blank) return 7'h7F;
        if (lz && idx > 0 && upper == 0) return 7'h7F;
        return seg_tab[upper % 16];
    endfunction

    always @(posedge clk) begin
        int idx;
        bit bnd;
        bit off;
        if (reset) begin
            m_cyc = 0; m_disp = '0; m_shadow = '0; m_pend = 1'b0;
            e_seg = 7'h7F; e_dig = 4'hF; e_ready = 1'b1; e_frame = 1'b0;
        end else begin
            idx = (m_cyc / SD) % ND;
            bnd = (m_cyc % FRAME_LEN) == FRAME_LEN - 1;
`ifdef HEX_DISPLAY_MUX_BLINK_EN
            off = ((m_cyc / FRAME_LEN) / BF) % 2 == 1;
`else
            off = 1'b0;
`endif
            e_seg      = model_seg(m_disp, idx, bus.blank_lz, off && bus.blink_mask[idx]);
            e_dig      = 4'hF;
            e_dig[idx] = 1'b0;
            e_frame    = bnd;
            if (bnd && m_pend) begin
                m_disp = m_shadow;
                m_pend = 1'b0;
            end else if (bus.load && !m_pend) begin
                m_shadow = bus.value;
                m_pend   = 1'b1;
            end
            e_ready = !m_pend;
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (chk_en)
            check("model", 32'({bus.seg, bus.dig_en, bus.ready, bus.frame}),
                  32'({e_seg, e_dig, e_ready, e_frame}));
    end

    // ---------------- helpers ----------------
    logic [6:0] cap [ND];

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        bus.load = 1'b0;
        step();
        chk_en = 1'b1;
        check("reset_seg",   32'(bus.seg),    32'h7F);
        check("reset_dig",   32'(bus.dig_en), 32'hF);
        check("reset_ready", 32'(bus.ready),  32'h1);
        check("reset_frame", 32'(bus.frame),  32'h0);
        reset = 1'b0;
    endtask

    task automatic load_value(input logic [15:0] v);
        bus.value = v;
        bus.load  = 1'b1;
        step();
        bus.load  = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 4 * FRAME_LEN; i++) begin
            step();
            if (bus.ready) break;
        end
        check(name, 32'(bus.ready), 32'h1);
    endtask

    task automatic capture_frame();
        for (int k = 0; k < ND; k++) cap[k] = 'x;
        for (int i = 0; i < FRAME_LEN; i++) begin
            step();
            for (int k = 0; k < ND; k++)
                if (bus.dig_en == 4'(~(1 << k))) cap[k] = bus.seg;
        end
    endtask

    typedef struct {
        logic [15:0]     value;
        logic            lz;
        logic [3:0][6:0] exp;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [3:0] pat [4];
        logic [6:0] d0_exp;

        vecs[0] = '{16'h12AF, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}};
        vecs[1] = '{16'h0030, 1'b1, {7'h7F, 7'h7F, 7'h30, 7'h40}};
        vecs[2] = '{16'h0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[3] = '{16'h0123, 1'b0, {7'h40, 7'h79, 7'h24, 7'h30}};
        vecs[4] = '{16'h4567, 1'b0, {7'h19, 7'h12, 7'h02, 7'h78}};
        vecs[5] = '{16'h89AB, 1'b0, {7'h00, 7'h18, 7'h08, 7'h03}};
        vecs[6] = '{16'hCDEF, 1'b0, {7'h46, 7'h21, 7'h06, 7'h0E}};
        vecs[7] = '{16'h0102, 1'b1, {7'h7F, 7'h79, 7'h40, 7'h24}};
        vecs[8] = '{16'h0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[9] = '{16'h8000, 1'b1, {7'h00, 7'h40, 7'h40, 7'h40}};
        pat = '{4'hE, 4'hD, 4'hB, 4'h7};

        bus.load = 1'b0; bus.value = '0; bus.blank_lz = 1'b0; bus.blink_mask = '0;
        @(negedge clk);
        do_reset();

        // Free-running scan after reset
        for (int i = 0; i < 32; i++) begin
            step();
            check($sformatf("scan_dig%0d", i),   32'(bus.dig_en), 32'(pat[(i / 4) % 4]));
            check($sformatf("scan_seg%0d", i),   32'(bus.seg),    32'h40);
            check($sformatf("scan_frame%0d", i), 32'(bus.frame),  32'((i == 15) || (i == 31)));
        end

        // Mid-frame load, second load ignored while busy
        repeat (3) step();
        load_value(16'h12AF);
        check("load_ready_low", 32'(bus.ready), 32'h0);
        load_value(16'hFFFF);
        check("busy_ready_low", 32'(bus.ready), 32'h0);
        for (int i = 0; i < 2 * FRAME_LEN; i++) begin
            step();
            check("pre_boundary_seg", 32'(bus.seg), 32'h40);
            if (bus.ready) break;
        end
        check("ready_after_boundary", 32'(bus.ready), 32'h1);
        check("ready_with_frame",     32'(bus.frame), 32'h1);
        capture_frame();
        check("12AF_d0", 32'(cap[0]), 32'h0E);
        check("12AF_d1", 32'(cap[1]), 32'h08);
        check("12AF_d2", 32'(cap[2]), 32'h24);
        check("12AF_d3", 32'(cap[3]), 32'h79);

        // Reset while a value is pending discards it
        repeat (2) step();
        load_value(16'hABCD);
        check("pend_before_reset", 32'(bus.ready), 32'h0);
        repeat (3) step();
        reset = 1'b1;
        step();
        check("rst_ready", 32'(bus.ready),  32'h1);
        check("rst_dig",   32'(bus.dig_en), 32'hF);
        check("rst_seg",   32'(bus.seg),    32'h7F);
        check("rst_frame", 32'(bus.frame),  32'h0);
        reset = 1'b0;
        step();
        check("restart_dig", 32'(bus.dig_en), 32'hE);
        check("restart_seg", 32'(bus.seg),    32'h40);
        capture_frame();
        for (int k = 0; k < ND; k++)
            check($sformatf("discard_d%0d", k), 32'(cap[k]), 32'h40);

        // Decoder and leading-zero table
        do_reset();
        foreach (vecs[i]) begin
            bus.blank_lz = vecs[i].lz;
            load_value(vecs[i].value);
            wait_ready($sformatf("vec%0d_ready", i));
            capture_frame();
            for (int k = 0; k < ND; k++)
                check($sformatf("vec%0d_d%0d", i, k), 32'(cap[k]), 32'(vecs[i].exp[k]));
        end

        // Blink on digit 0 (steady when the blink option is not built)
        bus.blank_lz = 1'b0;
        do_reset();
        bus.blink_mask = 4'b0001;
        load_value(16'h1234);
        wait_ready("blink_ready");
        for (int f = 0; f < 4; f++) begin
            capture_frame();
`ifdef HEX_DISPLAY_MUX_BLINK_EN
            d0_exp = (f == 1 || f == 2) ? 7'h7F : 7'h19;
`else
            d0_exp = 7'h19;
`endif
            check($sformatf("blink_f%0d_d0", f), 32'(cap[0]), 32'(d0_exp));
            check($sformatf("blink_f%0d_d1", f), 32'(cap[1]), 32'h30);
            check($sformatf("blink_f%0d_d2", f), 32'(cap[2]), 32'h24);
            check($sformatf("blink_f%0d_d3", f), 32'(cap[3]), 32'h79);
        end

        // Random traffic: loads regardless of ready, live control changes, rare resets
        for (int i = 0; i < 2000; i++) begin
            bus.load  = ($urandom_range(0, 3) == 0);
            bus.value = 16'($urandom);
            if ($urandom_range(0, 31) == 0) bus.blank_lz   = 1'($urandom);
            if ($urandom_range(0, 63) == 0) bus.blink_mask = 4'($urandom);
            reset = ($urandom_range(0, 399) == 0);
            step();
        end
        reset    = 1'b0;
        bus.load = 1'b0;
        step();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/hex_display_mux.md
HEX_DISPLAY_MUX -- requirements
Module: hex_display_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed hex digits (1..8).
REQ-002 Parameter SCAN_DIV, default 50000: clk cycles each digit is driven (>=2).
REQ-003 Parameter BLINK_FRAMES, default 64: scan frames per blink half-period (>=1).
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  system clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 load  in  1  request to capture value; accepted only when ready=1.
REQ-008 value  in  4*NUM_DIGITS  hex nibbles; nibble k (bits 4k+3:4k) is digit k; digit 0 is least significant.
REQ-009 blank_lz  in  1  when 1, leading-zero digits are blanked.
REQ-010 blink_mask  in  NUM_DIGITS  per-digit blink enable.
REQ-011 seg  out  7  active-low segments, bit0=a(top) .. bit6=g(middle).
REQ-012 dig_en  out  NUM_DIGITS  active-low one-hot digit enable.
REQ-013 ready  out  1  high when the shadow register is free.
REQ-014 frame  out  1  one-cycle pulse at each scan-frame boundary.

Function
REQ-015 Scan counter counts 0..SCAN_DIV-1 and wraps; tick = counter at SCAN_DIV-1.
REQ-016 Digit index advances on tick, 0..NUM_DIGITS-1, wrapping to 0.
REQ-017 Frame boundary = tick with index at NUM_DIGITS-1; frame is high in the cycle after it.
REQ-018 seg and dig_en are registered: they reflect the current index and display register one cycle after any change to either.
REQ-019 dig_en bit [index] = 0 and all other bits = 1.
REQ-020 Hex encoding (seg, hex), 0..F: 40,79,24,30,19,12,02,78,00,18,08,03,46,21,06,0E.
REQ-021 Blank digit: seg = 7F; dig_en behaves normally.
REQ-022 Handshake: load&ready -> shadow<=value, pending<=1; ready = ~pending.
REQ-023 load while ready=0 is ignored; shadow and pending are unchanged.
REQ-024 At a frame boundary with pending=1: display<=shadow and pending<=0, so ready rises the next cycle. No display change occurs mid-frame.
REQ-025 A load accepted in the frame-boundary cycle itself is applied at the following boundary.
REQ-026 Leading-zero blanking, with blank_lz=1: digit k is blank if it and every higher display digit are 0. Digit 0 is never blanked by this rule. blank_lz is sampled live.
REQ-027 Width rule: only nibbles 0..NUM_DIGITS-1 exist; there is no overflow or truncation logic.

Reset
REQ-028 On reset: seg=7F, dig_en all 1, ready=1, frame=0.
REQ-029 On reset: display=0, shadow=0, pending=0, index=0, scan counter=0, blink counter=0, blink phase=on.
REQ-030 Reset mid-frame or with pending=1 discards the pending value; the first enabled digit after reset is digit 0.

Configuration
REQ-031 Macro HEX_DISPLAY_MUX_BLINK_EN defined: blink phase toggles every BLINK_FRAMES frame boundaries. In the off phase, digits with blink_mask[k]=1 are blank.
REQ-032 Macro HEX_DISPLAY_MUX_BLINK_EN undefined: no blink counter is built, blink_mask is ignored, and no blink blanking occurs.

Verification (NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2)
REQ-033 Reset then run 32 cycles -> dig_en cycles E,D,B,7 with 4 cycles each; seg=40 throughout; frame pulses every 16 cycles.
REQ-034 load=1, value=16'h12AF mid-frame -> ready=0 next cycle; digits stay 0 until the boundary; then digits 0..3 show 0E,08,24,79 and ready=1.
REQ-035 Second load while ready=0 with value=16'hFFFF -> ignored; display shows 16'h12AF after the boundary.
REQ-036 blank_lz=1, value=16'h0030 -> digits 3,2 seg=7F, digit1=30, digit0=40; value=0 -> only digit0 shows 40.
REQ-037 With the blink macro, blink_mask=4'b0001, value=16'h1234 -> digit0 alternates 19/7F every 2 frames; other digits are steady.
REQ-038 Assert reset while pending=1 mid-frame -> next cycle: ready=1, dig_en=F, seg=7F; then the digit-0 scan restarts showing 40.
